// File: rtl/inst_encoder_loader_if.sv
// Request/write-port bundle for the instruction encoder/loader.
// The slave view is the loader itself; the master view drives requests and observes writes.
interface inst_encoder_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              full;
  logic              err;
  logic              done;

  modport master (
    output start, finish, in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, full, err, done
  );

  modport slave (
    input  start, finish, in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, busy, full, err, done
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and writes them
// sequentially into instruction memory during a start/finish load session.
module inst_encoder_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_encoder_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [2:0]        OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept_c;
  logic              legal_c;
  logic [CNT_W-1:0]  count_inc_c;
  logic [31:0]       enc_c;

  // Fixed MIPS field positions; op 7 has no encoding.
  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (op)
      3'd0:    w = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      3'd1:    w = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      3'd2:    w = {6'h0D, rs, rt, imm};
      3'd3:    w = {6'h23, rs, rt, imm};
      3'd4:    w = {6'h2B, rs, rt, imm};
      3'd5:    w = {6'h04, rs, rt, imm};
      3'd6:    w = {6'h02, 10'h000, imm};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always_comb begin
    accept_c    = bus.in_valid & bus.in_ready;
    legal_c     = (bus.in_op != OP_ILLEGAL);
    count_inc_c = bus.count + CNT_W'(1);
    enc_c       = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= BASE_C;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      bus.count     <= '0;
      bus.busy      <= 1'b0;
      bus.full      <= 1'b0;
      bus.err       <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            ptr          <= BASE_C;
            bus.count    <= '0;
            bus.full     <= 1'b0;
            bus.err      <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_c) begin
            if (legal_c) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= ptr;
              bus.mem_wdata <= enc_c;
              ptr           <= ptr + ADDR_W'(1);
              bus.count     <= count_inc_c;
              if (count_inc_c == DEPTH_C) bus.full <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
          // finish takes priority over filling up; the last accept is still written.
          if (bus.finish) begin
            state        <= IDLE;
            bus.done     <= 1'b1;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
          end else if (accept_c && legal_c && (count_inc_c == DEPTH_C)) begin
            state        <= FULL;
            bus.in_ready <= 1'b0;
          end
        end
        FULL: begin
          if (bus.finish) begin
            state    <= IDLE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: a DEPTH=1024 instance and a DEPTH=4
// instance share one stimulus stream; expected words are hand-encoded constants.
module tb_inst_encoder_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  inst_encoder_loader_if #(.ADDR_W(10)) bus  ();
  inst_encoder_loader_if #(.ADDR_W(10)) bus4 ();

  assign bus4.start    = bus.start;
  assign bus4.finish   = bus.finish;
  assign bus4.in_valid = bus.in_valid;
  assign bus4.in_op    = bus.in_op;
  assign bus4.in_rs    = bus.in_rs;
  assign bus4.in_rt    = bus.in_rt;
  assign bus4.in_rd    = bus.in_rd;
  assign bus4.in_imm   = bus.in_imm;

  inst_encoder_loader #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  inst_encoder_loader #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_finish();
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
  endtask

  logic [31:0] burst_exp [5];

  initial begin
    burst_exp[0] = 32'h340400FF;
    burst_exp[1] = 32'h8C850008;
    burst_exp[2] = 32'hAC85FFFC;
    burst_exp[3] = 32'h10220003;
    burst_exp[4] = 32'h08000010;

    bus.start  = 1'b0;
    bus.finish = 1'b0;
    req(3'd0, 5'd0, 5'd0, 5'd0, 16'h0);

    // Reset held for two cycles with in_valid high
    tick();
    tick();
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_full",      32'(bus.full),      32'h0);
    chk("rst_err",       32'(bus.err),       32'h0);
    chk("rst_done",      32'(bus.done),      32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_in_ready", 32'(bus.in_ready), 32'h0);
      chk("idle_mem_we",   32'(bus.mem_we),   32'h0);
      chk("idle_count",    32'(bus.count),    32'h0);
      chk("idle_busy",     32'(bus.busy),     32'h0);
    end
    bus.in_valid = 1'b0;

    // Single ADD
    pulse_start();
    chk("load_in_ready", 32'(bus.in_ready), 32'h1);
    chk("load_busy",     32'(bus.busy),     32'h1);
    req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("add_we",    32'(bus.mem_we),    32'h1);
    chk("add_addr",  32'(bus.mem_addr),  32'h0);
    chk("add_data",  bus.mem_wdata,      32'h00221820);
    chk("add_count", 32'(bus.count),     32'h1);
    tick();
    chk("add_we_after", 32'(bus.mem_we), 32'h0);
    pulse_finish();
    chk("fin_done",     32'(bus.done),     32'h1);
    chk("fin_busy",     32'(bus.busy),     32'h0);
    chk("fin_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("fin_done_one", 32'(bus.done),  32'h0);
    chk("idle_count_h", 32'(bus.count), 32'h1);

    // Mixed back-to-back burst
    pulse_start();
    chk("restart_count", 32'(bus.count), 32'h0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: req(3'd2, 5'd0, 5'd4, 5'd0, 16'h00FF);
        1: req(3'd3, 5'd4, 5'd5, 5'd0, 16'h0008);
        2: req(3'd4, 5'd4, 5'd5, 5'd0, 16'hFFFC);
        3: req(3'd5, 5'd1, 5'd2, 5'd0, 16'h0003);
        default: req(3'd6, 5'd0, 5'd0, 5'd0, 16'h0010);
      endcase
      tick();
      chk("burst_we",   32'(bus.mem_we),   32'h1);
      chk("burst_addr", 32'(bus.mem_addr), 32'(i));
      chk("burst_data", bus.mem_wdata,     burst_exp[i]);
    end
    bus.in_valid = 1'b0;
    chk("burst_count", 32'(bus.count), 32'h5);
    pulse_finish();

    // Illegal op between two SUBs
    pulse_start();
    req(3'd1, 5'd1, 5'd1, 5'd1, 16'h0);
    tick();
    chk("sub0_we",   32'(bus.mem_we),   32'h1);
    chk("sub0_addr", 32'(bus.mem_addr), 32'h0);
    chk("sub0_data", bus.mem_wdata,     32'h00210822);
    req(3'd7, 5'd1, 5'd1, 5'd1, 16'h0);
    tick();
    chk("ill_we",    32'(bus.mem_we), 32'h0);
    chk("ill_err",   32'(bus.err),    32'h1);
    chk("ill_count", 32'(bus.count),  32'h1);
    req(3'd1, 5'd1, 5'd1, 5'd1, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("sub1_we",    32'(bus.mem_we),   32'h1);
    chk("sub1_addr",  32'(bus.mem_addr), 32'h1);
    chk("sub1_data",  bus.mem_wdata,     32'h00210822);
    chk("sub1_count", 32'(bus.count),    32'h2);
    chk("err_sticky", 32'(bus.err),      32'h1);
    pulse_finish();
    chk("err_idle", 32'(bus.err), 32'h1);
    pulse_start();
    chk("err_clear", 32'(bus.err), 32'h0);

    // Fill the DEPTH=4 instance with six continuous requests
    req(3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("full_we", 32'(bus4.mem_we), (i < 4) ? 32'h1 : 32'h0);
      if (i < 4) chk("full_addr", 32'(bus4.mem_addr), 32'(i));
      if (i == 2) chk("full_ready_pre", 32'(bus4.in_ready), 32'h1);
      if (i == 3) begin
        chk("full_flag",  32'(bus4.full),     32'h1);
        chk("full_ready", 32'(bus4.in_ready), 32'h0);
      end
    end
    bus.in_valid = 1'b0;
    chk("full_count4",  32'(bus4.count), 32'h4);
    chk("big_count6",   32'(bus.count),  32'h6);
    chk("big_not_full", 32'(bus.full),   32'h0);
    pulse_finish();
    chk("full_done", 32'(bus4.done), 32'h1);
    chk("full_busy", 32'(bus4.busy), 32'h0);
    tick();
    chk("full_done_one", 32'(bus4.done),  32'h0);
    chk("full_count_h",  32'(bus4.count), 32'h4);

    // Same-cycle finish and accept
    pulse_start();
    req(3'd1, 5'd1, 5'd1, 5'd1, 16'h0);
    bus.finish = 1'b1;
    tick();
    bus.finish   = 1'b0;
    bus.in_valid = 1'b0;
    chk("fa_we",    32'(bus.mem_we),   32'h1);
    chk("fa_addr",  32'(bus.mem_addr), 32'h0);
    chk("fa_data",  bus.mem_wdata,     32'h00210822);
    chk("fa_done",  32'(bus.done),     32'h1);
    chk("fa_busy",  32'(bus.busy),     32'h0);
    chk("fa_count", 32'(bus.count),    32'h1);
    tick();
    chk("fa_we_after", 32'(bus.mem_we), 32'h0);

    // Reset one cycle after an accept
    pulse_start();
    req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    chk("mr_we_pre", 32'(bus.mem_we), 32'h1);
    rst = 1'b0;
    tick();
    chk("mr_we",       32'(bus.mem_we),    32'h0);
    chk("mr_count",    32'(bus.count),     32'h0);
    chk("mr_busy",     32'(bus.busy),      32'h0);
    chk("mr_in_ready", 32'(bus.in_ready),  32'h0);
    chk("mr_addr",     32'(bus.mem_addr),  32'h0);
    chk("mr_wdata",    bus.mem_wdata,      32'h0);
    chk("mr_done",     32'(bus.done),      32'h0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("mr_we_idle", 32'(bus.mem_we), 32'h0);
    pulse_start();
    req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("mr_post_we",   32'(bus.mem_we),   32'h1);
    chk("mr_post_addr", 32'(bus.mem_addr), 32'h0);
    chk("mr_post_data", bus.mem_wdata,     32'h00221820);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
